// File: rtl/frog_position_ctrl.sv
// ---------------------------------------------------------------------------
// frog_position_ctrl
//
// Player-position tracker for the Frogger playfield. Held direction buttons
// become single hops through rising-edge detection. Each accepted hop moves
// the frog one cell. The position is clamped to the playfield, or wraps
// horizontally when enabled. A cooldown follows each hop, and a goal state
// latches once the frog reaches the top row.
//
// Optional feature macro:
//   FROG_WRAP_X_EN - when defined, L at x==X_MAX wraps to 0 and R at x==0
//                    wraps to X_MAX. Both count as full hops. Vertical motion
//                    always clamps.
//
// Ports:
//   clock      in   1      system clock
//   RST        in   1      synchronous active-high reset
//   L          in   1      left button level (increments x)
//   R          in   1      right button level (decrements x)
//   U          in   1      up button level (increments y)
//   D          in   1      down button level (decrements y)
//   respawn    in   1      return frog to start; hop_count is kept
//   x          out  X_W    current column
//   y          out  Y_W    current row
//   moved      out  1      one-cycle pulse on each accepted hop
//   at_goal    out  1      high while in the GOAL state
//   hop_count  out  CNT_W  accepted hops, wraps naturally
// ---------------------------------------------------------------------------
module frog_position_ctrl #(
  parameter int X_W          = 4,
  parameter int Y_W          = 4,
  parameter int X_MAX        = 15,
  parameter int Y_MAX        = 15,
  parameter int X_START      = 7,
  parameter int Y_START      = 0,
  parameter int HOP_COOLDOWN = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             RST,
  input  logic             L,
  input  logic             R,
  input  logic             U,
  input  logic             D,
  input  logic             respawn,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             moved,
  output logic             at_goal,
  output logic [CNT_W-1:0] hop_count
);

  // The cooldown counter only has to hold HOP_COOLDOWN. It keeps at least
  // one bit so the design stays legal when the cooldown is disabled.
  localparam int CD_W = (HOP_COOLDOWN > 1) ? $clog2(HOP_COOLDOWN + 1) : 1;

  localparam logic [X_W-1:0]  X_LIM   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]  Y_LIM   = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]  X_HOME  = X_W'(X_START);
  localparam logic [Y_W-1:0]  Y_HOME  = Y_W'(Y_START);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(HOP_COOLDOWN);

  typedef enum logic [1:0] {
    IDLE,
    COOLDOWN,
    GOAL
  } state_t;

  state_t state;
  state_t state_next;

  logic [CD_W-1:0]  cd_cnt;
  logic [CD_W-1:0]  cd_next;

  logic             l_hist;
  logic             r_hist;
  logic             u_hist;
  logic             d_hist;

  logic             press_l;
  logic             press_r;
  logic             press_u;
  logic             press_d;

  logic             hop;
  logic [X_W-1:0]   x_hop;
  logic [Y_W-1:0]   y_hop;

  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;
  logic             moved_next;
  logic [CNT_W-1:0] count_next;

  // Button history for edge detection. It follows the inputs every cycle,
  // whatever the state, so a button held through cooldown or GOAL never
  // shows up later as a stale press. Reset drives it to 1. A button held
  // through reset therefore has to be released and pressed again before it
  // produces a hop.
  always_ff @(posedge clock) begin
    if (RST) begin
      l_hist <= 1'b1;
      r_hist <= 1'b1;
      u_hist <= 1'b1;
      d_hist <= 1'b1;
    end else begin
      l_hist <= L;
      r_hist <= R;
      u_hist <= U;
      d_hist <= D;
    end
  end

  assign press_l = L & ~l_hist;
  assign press_r = R & ~r_hist;
  assign press_u = U & ~u_hist;
  assign press_d = D & ~d_hist;

  // Select the single candidate hop for this cycle and apply the playfield
  // bounds. Priority is L > R > U > D. If the winning press is blocked by a
  // boundary, the whole cycle produces no hop. A lower-priority press in the
  // same cycle is dropped rather than tried in its place.
  always_comb begin
    hop   = 1'b0;
    x_hop = x;
    y_hop = y;
    if (press_l) begin
      if (x != X_LIM) begin
        x_hop = x + X_W'(1);
        hop   = 1'b1;
      end
`ifdef FROG_WRAP_X_EN
      else begin
        x_hop = '0;
        hop   = 1'b1;
      end
`endif
    end else if (press_r) begin
      if (x != '0) begin
        x_hop = x - X_W'(1);
        hop   = 1'b1;
      end
`ifdef FROG_WRAP_X_EN
      else begin
        x_hop = X_LIM;
        hop   = 1'b1;
      end
`endif
    end else if (press_u) begin
      if (y != Y_LIM) begin
        y_hop = y + Y_W'(1);
        hop   = 1'b1;
      end
    end else if (press_d) begin
      if (y != '0) begin
        y_hop = y - Y_W'(1);
        hop   = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  // Hops are only accepted in IDLE. A hop that lands on the top row goes
  // straight to GOAL, which wins over COOLDOWN. COOLDOWN counts down and
  // returns to IDLE on the cycle its counter reads 1, so the next press can
  // land HOP_COOLDOWN+1 edges after the hop. Respawn overrides everything
  // except reset. It sends the frog home and keeps the hop count.
  always_comb begin
    state_next = state;
    cd_next    = cd_cnt;
    x_next     = x;
    y_next     = y;
    moved_next = 1'b0;
    count_next = hop_count;

    case (state)
      IDLE: begin
        if (hop) begin
          x_next     = x_hop;
          y_next     = y_hop;
          moved_next = 1'b1;
          count_next = hop_count + CNT_W'(1);
          if (y_hop == Y_LIM) begin
            state_next = GOAL;
          end else if (HOP_COOLDOWN > 0) begin
            state_next = COOLDOWN;
            cd_next    = CD_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (cd_cnt <= CD_W'(1)) begin
          state_next = IDLE;
          cd_next    = '0;
        end else begin
          cd_next = cd_cnt - CD_W'(1);
        end
      end
      GOAL: begin
        state_next = GOAL;
      end
      default: begin
        state_next = IDLE;
        cd_next    = '0;
      end
    endcase

    if (respawn) begin
      state_next = IDLE;
      cd_next    = '0;
      x_next     = X_HOME;
      y_next     = Y_HOME;
      moved_next = 1'b0;
      count_next = hop_count;
    end
  end

  // State and output registers. Every output is registered, so a press
  // sampled on an edge is visible immediately after that same edge.
  // at_goal is registered from the next state so it tracks GOAL exactly.
  always_ff @(posedge clock) begin
    if (RST) begin
      state     <= IDLE;
      cd_cnt    <= '0;
      x         <= X_HOME;
      y         <= Y_HOME;
      moved     <= 1'b0;
      at_goal   <= 1'b0;
      hop_count <= '0;
    end else begin
      state     <= state_next;
      cd_cnt    <= cd_next;
      x         <= x_next;
      y         <= y_next;
      moved     <= moved_next;
      at_goal   <= (state_next == GOAL);
      hop_count <= count_next;
    end
  end

endmodule

// File: tb/tb_frog_position_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frog_position_ctrl
//
// Directed bench for frog_position_ctrl with default parameters
// (X_START=7, Y_START=0, X_MAX=Y_MAX=15, HOP_COOLDOWN=3).
// Inputs change on the falling edge and outputs are sampled on the next
// falling edge, so every sample sits half a period after the active edge.
// Expected values are written out by hand. Where FROG_WRAP_X_EN changes an
// outcome, the expectation is selected with the same macro.
// ---------------------------------------------------------------------------
module tb_frog_position_ctrl;

`ifdef FROG_WRAP_X_EN
  localparam int WRAP = 1;
`else
  localparam int WRAP = 0;
`endif

  logic        clock;
  logic        RST;
  logic        L;
  logic        R;
  logic        U;
  logic        D;
  logic        respawn;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        moved;
  logic        at_goal;
  logic [15:0] hop_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  frog_position_ctrl dut (
    .clock     (clock),
    .RST       (RST),
    .L         (L),
    .R         (R),
    .U         (U),
    .D         (D),
    .respawn   (respawn),
    .x         (x),
    .y         (y),
    .moved     (moved),
    .at_goal   (at_goal),
    .hop_count (hop_count)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, let the rising edge sample them, then return
  // on the following falling edge ready to check or drive again.
  task automatic applyStimulus(input logic l, input logic r, input logic u,
                               input logic d, input logic resp, input logic rst);
    L       = l;
    R       = r;
    U       = u;
    D       = d;
    respawn = resp;
    RST     = rst;
    @(posedge clock);
    @(negedge clock);
  endtask

  // All inputs low for n cycles
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Compare every output against the hand-computed expectation
  task automatic checkOutput(input string tag, input logic [3:0] ex_x,
                             input logic [3:0] ex_y, input logic ex_moved,
                             input logic ex_goal, input int ex_count);
    logic [15:0] ec;
    ec = 16'(ex_count);
    checks++;
    assert (x === ex_x) else begin
      errors++;
      $error("[TB] FAIL %s.x observed=%0d expected=%0d", tag, x, ex_x);
    end
    checks++;
    assert (y === ex_y) else begin
      errors++;
      $error("[TB] FAIL %s.y observed=%0d expected=%0d", tag, y, ex_y);
    end
    checks++;
    assert (moved === ex_moved) else begin
      errors++;
      $error("[TB] FAIL %s.moved observed=%b expected=%b", tag, moved, ex_moved);
    end
    checks++;
    assert (at_goal === ex_goal) else begin
      errors++;
      $error("[TB] FAIL %s.at_goal observed=%b expected=%b", tag, at_goal, ex_goal);
    end
    checks++;
    assert (hop_count === ec) else begin
      errors++;
      $error("[TB] FAIL %s.hop_count observed=%0d expected=%0d", tag, hop_count, ec);
    end
  endtask

  initial begin
    RST = 1'b1; L = 1'b1; R = 1'b0; U = 1'b0; D = 1'b0; respawn = 1'b0;

    // Reset with L held: reset values, then no hop while L stays held
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("reset", 4'd7, 4'd0, 1'b0, 1'b0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("held_thru_reset", 4'd7, 4'd0, 1'b0, 1'b0, 0);

    // Release, then a single press: one hop to x=8
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    exp_count = 1;
    checkOutput("first_press", 4'd8, 4'd0, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pulse_end", 4'd8, 4'd0, 1'b0, 1'b0, exp_count);
    idleCycles(3);

    // L held for 10 cycles: exactly one hop
    applyStimulus(1, 0, 0, 0, 0, 0);
    exp_count = 2;
    checkOutput("hold_first", 4'd9, 4'd0, 1'b1, 1'b0, exp_count);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("hold_end", 4'd9, 4'd0, 1'b0, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Respawn returns home and keeps the count
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("respawn1", 4'd7, 4'd0, 1'b0, 1'b0, exp_count);

    // Cooldown: press at N, re-press at N+2 (discarded) and N+4 (accepted)
    applyStimulus(1, 0, 0, 0, 0, 0);
    exp_count = 3;
    checkOutput("cd_press_n", 4'd8, 4'd0, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("cd_press_n2", 4'd8, 4'd0, 1'b0, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    exp_count = 4;
    checkOutput("cd_press_n4", 4'd9, 4'd0, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // L and U together: L wins, U is dropped; a later U moves y
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    exp_count = 5;
    checkOutput("l_and_u", 4'd8, 4'd0, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    exp_count = 6;
    checkOutput("u_after_cd", 4'd8, 4'd1, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Respawn wins over a simultaneous press
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("respawn_vs_press", 4'd7, 4'd0, 1'b0, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Seven R hops from x=7 down to x=0
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      idleCycles(2);
    end
    exp_count = 13;
    checkOutput("r_to_zero", 4'd0, 4'd0, 1'b0, 1'b0, exp_count);

    // Eighth R: blocked at the edge, or wraps to 15 when wrap is enabled
    applyStimulus(0, 1, 0, 0, 0, 0);
    exp_count = 13 + WRAP;
    checkOutput("r_edge", (WRAP != 0) ? 4'd15 : 4'd0, 4'd0, 1'(WRAP), 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // D at y=0 is blocked and starts no cooldown: the next U is taken at once
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("d_blocked", (WRAP != 0) ? 4'd15 : 4'd0, 4'd0, 1'b0, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    exp_count = 14 + WRAP;
    checkOutput("u_after_block", (WRAP != 0) ? 4'd15 : 4'd0, 4'd1, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Respawn, then fifteen U hops to the goal row
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      idleCycles(2);
    end
    exp_count = 28 + WRAP;
    checkOutput("row14", 4'd7, 4'd14, 1'b0, 1'b0, exp_count);
    applyStimulus(0, 0, 1, 0, 0, 0);
    exp_count = 29 + WRAP;
    checkOutput("goal_reached", 4'd7, 4'd15, 1'b1, 1'b1, exp_count);

    // GOAL holds and ignores presses
    applyStimulus(0, 0, 0, 0, 0, 0);
    idleCycles(4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("goal_hold", 4'd7, 4'd15, 1'b0, 1'b1, exp_count);

    // Respawn leaves GOAL and keeps the count
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("goal_respawn", 4'd7, 4'd0, 1'b0, 1'b0, exp_count);

    // RST mid-cooldown: back to reset values, then an immediate press works
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    exp_count = 30 + WRAP;
    checkOutput("pre_rst_hop", 4'd8, 4'd0, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 1);
    exp_count = 0;
    checkOutput("rst_mid_cd", 4'd7, 4'd0, 1'b0, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    exp_count = 1;
    checkOutput("post_rst_hop", 4'd8, 4'd0, 1'b1, 1'b0, exp_count);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
